// File: rtl/wb_write_arbiter.sv
// Register file write-port arbiter.
// The ALU writeback path always wins the port. Load returns are buffered
// in a circular queue with a per-entry live bit. An ALU write to the same
// destination kills any older queued load to that register (write-after-write
// ordering), and a dead head entry is popped without producing a write.
module wb_write_arbiter #(
    parameter int REG_WIDTH = 64,
    parameter int REG_COUNT = 32,
    parameter int LQ_DEPTH  = 4,
    localparam int AW = $clog2(REG_COUNT),
    localparam int PW = $clog2(LQ_DEPTH),
    localparam int CW = PW + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 alu_valid_i,
    input  logic [AW-1:0]        alu_rd_i,
    input  logic [REG_WIDTH-1:0] alu_data_i,
    input  logic                 ld_valid_i,
    output logic                 ld_ready_o,
    input  logic [AW-1:0]        ld_rd_i,
    input  logic [REG_WIDTH-1:0] ld_data_i,
    output logic                 wb_we_o,
    output logic [AW-1:0]        wb_waddr_o,
    output logic [REG_WIDTH-1:0] wb_wdata_o,
    input  logic [AW-1:0]        query_addr_i,
    output logic                 query_pending_o,
    output logic [CW-1:0]        lq_count_o
);

    logic [AW-1:0]        rd_q   [LQ_DEPTH];
    logic [REG_WIDTH-1:0] data_q [LQ_DEPTH];
    logic [LQ_DEPTH-1:0]  live_q, live_d;
    logic [PW-1:0]        head_q, head_d;
    logic [PW-1:0]        tail_q, tail_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 we_q, we_d;
    logic [AW-1:0]        waddr_q, waddr_d;
    logic [REG_WIDTH-1:0] wdata_q, wdata_d;

    logic alu_sel;
    logic pop;
    logic push;

    // Handshake and arbitration decisions for this cycle; register 0 is never written.
    always_comb begin
        ld_ready_o = !rst && (count_q != CW'(LQ_DEPTH));
        alu_sel    = alu_valid_i && (alu_rd_i != '0);
        pop        = !alu_sel && (count_q != '0);
        push       = ld_valid_i && ld_ready_o && (ld_rd_i != '0);
    end

    // Next-state for write port, queue pointers, occupancy and live bits.
    always_comb begin
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        live_d  = live_q;

        if (alu_sel) begin
            // Older queued loads to the same register would overwrite the younger ALU value.
            for (int i = 0; i < LQ_DEPTH; i++) begin
                if (rd_q[i] == alu_rd_i) begin
                    live_d[i] = 1'b0;
                end
            end
            we_d    = 1'b1;
            waddr_d = alu_rd_i;
            wdata_d = alu_data_i;
        end else if (pop) begin
            if (live_q[head_q]) begin
                we_d    = 1'b1;
                waddr_d = rd_q[head_q];
                wdata_d = data_q[head_q];
            end
            live_d[head_q] = 1'b0;
            head_d         = head_q + 1'b1;
        end

        // Applied after the kill so a same-edge load to alu_rd stays live.
        if (push) begin
            live_d[tail_q] = 1'b1;
            tail_d         = tail_q + 1'b1;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Control state and registered write port, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            live_q  <= '0;
        end else begin
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            live_q  <= live_d;
        end
    end

    // Queue payload storage; validity is carried entirely by live_q and count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            rd_q[tail_q]   <= ld_rd_i;
            data_q[tail_q] <= ld_data_i;
        end
    end

    // Decode stall query: any live queued load targeting query_addr_i.
    always_comb begin
        query_pending_o = 1'b0;
        for (int i = 0; i < LQ_DEPTH; i++) begin
            if (live_q[i] && (rd_q[i] == query_addr_i)) begin
                query_pending_o = 1'b1;
            end
        end
        if (query_addr_i == '0) begin
            query_pending_o = 1'b0;
        end
    end

    assign wb_we_o    = we_q;
    assign wb_waddr_o = waddr_q;
    assign wb_wdata_o = wdata_q;
    assign lq_count_o = count_q;

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Bench for wb_write_arbiter: a vector table for single-cycle behaviour,
// then hand-written sequences for full queue, reset mid-stream and wrap-around.
module tb_wb_write_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        alu_valid_i = 1'b0;
    logic [4:0]  alu_rd_i = '0;
    logic [63:0] alu_data_i = '0;
    logic        ld_valid_i = 1'b0;
    logic        ld_ready_o;
    logic [4:0]  ld_rd_i = '0;
    logic [63:0] ld_data_i = '0;
    logic        wb_we_o;
    logic [4:0]  wb_waddr_o;
    logic [63:0] wb_wdata_o;
    logic [4:0]  query_addr_i = '0;
    logic        query_pending_o;
    logic [2:0]  lq_count_o;

    int checks = 0;
    int errors = 0;

    wb_write_arbiter #(.REG_WIDTH(64), .REG_COUNT(32), .LQ_DEPTH(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .alu_valid_i     (alu_valid_i),
        .alu_rd_i        (alu_rd_i),
        .alu_data_i      (alu_data_i),
        .ld_valid_i      (ld_valid_i),
        .ld_ready_o      (ld_ready_o),
        .ld_rd_i         (ld_rd_i),
        .ld_data_i       (ld_data_i),
        .wb_we_o         (wb_we_o),
        .wb_waddr_o      (wb_waddr_o),
        .wb_wdata_o      (wb_wdata_o),
        .query_addr_i    (query_addr_i),
        .query_pending_o (query_pending_o),
        .lq_count_o      (lq_count_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        alu_v;
        logic [4:0]  alu_rd;
        logic [63:0] alu_d;
        logic        ld_v;
        logic [4:0]  ld_rd;
        logic [63:0] ld_d;
        logic [4:0]  q;
        logic        e_we;
        logic [4:0]  e_addr;
        logic [63:0] e_data;
        logic [2:0]  e_cnt;
        logic        e_ready;
        logic        e_pend;
    } vec_t;

    vec_t vt[14];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic av, input logic [4:0] ar, input logic [63:0] ad,
                         input logic lv, input logic [4:0] lr, input logic [63:0] ld);
        alu_valid_i = av;
        alu_rd_i    = ar;
        alu_data_i  = ad;
        ld_valid_i  = lv;
        ld_rd_i     = lr;
        ld_data_i   = ld;
    endtask

    initial begin
        //          alu_v rd  data   ld_v rd  data   q   we addr data   cnt rdy pend
        vt[0]  = '{1'b1, 5,  'hAA, 1'b1, 7,  'h70, 7,  1, 5,  'hAA, 1, 1, 1};
        vt[1]  = '{1'b1, 5,  'hAA, 1'b1, 8,  'h80, 8,  1, 5,  'hAA, 2, 1, 1};
        vt[2]  = '{1'b1, 5,  'hAA, 1'b0, 0,  'h0,  7,  1, 5,  'hAA, 2, 1, 1};
        vt[3]  = '{1'b0, 0,  'h0,  1'b0, 0,  'h0,  7,  1, 7,  'h70, 1, 1, 0};
        vt[4]  = '{1'b0, 0,  'h0,  1'b0, 0,  'h0,  8,  1, 8,  'h80, 0, 1, 0};
        vt[5]  = '{1'b0, 0,  'h0,  1'b0, 0,  'h0,  8,  0, 8,  'h80, 0, 1, 0};
        vt[6]  = '{1'b0, 0,  'h0,  1'b1, 9,  'h11, 9,  0, 8,  'h80, 1, 1, 1};
        vt[7]  = '{1'b1, 9,  'h22, 1'b0, 0,  'h0,  9,  1, 9,  'h22, 1, 1, 0};
        vt[8]  = '{1'b0, 0,  'h0,  1'b0, 0,  'h0,  9,  0, 9,  'h22, 0, 1, 0};
        vt[9]  = '{1'b1, 0,  'h66, 1'b1, 0,  'h55, 0,  0, 9,  'h22, 0, 1, 0};
        vt[10] = '{1'b1, 0,  'h66, 1'b1, 4,  'h44, 4,  0, 9,  'h22, 1, 1, 1};
        vt[11] = '{1'b1, 0,  'h66, 1'b1, 0,  'h55, 0,  1, 4,  'h44, 0, 1, 0};
        vt[12] = '{1'b1, 6,  'h62, 1'b1, 6,  'h61, 6,  1, 6,  'h62, 1, 1, 1};
        vt[13] = '{1'b0, 0,  'h0,  1'b0, 0,  'h0,  6,  1, 6,  'h61, 0, 1, 0};

        // Reset values while rst is held.
        tick();
        tick();
        chk("rst_we", wb_we_o, 0);
        chk("rst_waddr", wb_waddr_o, 0);
        chk("rst_wdata", wb_wdata_o, 0);
        chk("rst_cnt", lq_count_o, 0);
        chk("rst_ready", ld_ready_o, 0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", ld_ready_o, 1);

        // Table: ALU priority, WAW kill, x0 filtering, same-edge WAW.
        for (int i = 0; i < 14; i++) begin
            drive(vt[i].alu_v, vt[i].alu_rd, vt[i].alu_d, vt[i].ld_v, vt[i].ld_rd, vt[i].ld_d);
            query_addr_i = vt[i].q;
            tick();
            chk($sformatf("v%0d_we", i), wb_we_o, vt[i].e_we);
            chk($sformatf("v%0d_waddr", i), wb_waddr_o, vt[i].e_addr);
            chk($sformatf("v%0d_wdata", i), wb_wdata_o, vt[i].e_data);
            chk($sformatf("v%0d_cnt", i), lq_count_o, vt[i].e_cnt);
            chk($sformatf("v%0d_ready", i), ld_ready_o, vt[i].e_ready);
            chk($sformatf("v%0d_pend", i), query_pending_o, vt[i].e_pend);
        end

        // Full queue: ALU traffic starves the queue until it fills.
        for (int i = 0; i < 4; i++) begin
            drive(1, 3, 'h33, 1, 5'(11 + i), 64'hB0 + 64'(i));
            tick();
            chk($sformatf("full_alu_we%0d", i), wb_we_o, 1);
            chk($sformatf("full_alu_addr%0d", i), wb_waddr_o, 3);
        end
        chk("full_cnt", lq_count_o, 4);
        chk("full_ready", ld_ready_o, 0);
        drive(1, 3, 'h33, 1, 15, 'hFF);
        query_addr_i = 15;
        #1;
        chk("full_ready_with_valid", ld_ready_o, 0);
        tick();
        chk("full_5th_cnt", lq_count_o, 4);
        chk("full_5th_pend", query_pending_o, 0);
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("drain_we%0d", i), wb_we_o, 1);
            chk($sformatf("drain_addr%0d", i), wb_waddr_o, 5'(11 + i));
            chk($sformatf("drain_data%0d", i), wb_wdata_o, 64'hB0 + 64'(i));
            chk($sformatf("drain_cnt%0d", i), lq_count_o, 3'(3 - i));
            chk($sformatf("drain_ready%0d", i), ld_ready_o, 1);
        end

        // Reset mid-stream with three loads queued behind ALU traffic.
        for (int i = 0; i < 3; i++) begin
            drive(1, 3, 'h33, 1, 5'(20 + i), 64'hC0 + 64'(i));
            tick();
        end
        drive(1, 3, 'h33, 0, 0, 0);
        query_addr_i = 20;
        #1;
        chk("mid_cnt_before", lq_count_o, 3);
        chk("mid_pend_before", query_pending_o, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_we", wb_we_o, 0);
        chk("mid_rst_cnt", lq_count_o, 0);
        chk("mid_rst_ready", ld_ready_o, 0);
        chk("mid_rst_pend", query_pending_o, 0);
        tick();
        chk("mid_rst_ready_held", ld_ready_o, 0);
        chk("mid_rst_we_held", wb_we_o, 0);
        drive(0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        #1;
        chk("mid_release_ready", ld_ready_o, 1);
        tick();
        chk("mid_release_we", wb_we_o, 0);
        chk("mid_release_cnt", lq_count_o, 0);

        // Wrap-around: ten back-to-back loads, one write per cycle, two-edge latency.
        for (int k = 0; k <= 10; k++) begin
            if (k < 10) drive(0, 0, 0, 1, 5'(k + 1), 64'h100 + 64'(k + 1));
            else        drive(0, 0, 0, 0, 0, 0);
            tick();
            if (k == 0) begin
                chk("wrap_first_we", wb_we_o, 0);
            end else begin
                chk($sformatf("wrap_we%0d", k), wb_we_o, 1);
                chk($sformatf("wrap_addr%0d", k), wb_waddr_o, 5'(k));
                chk($sformatf("wrap_data%0d", k), wb_wdata_o, 64'h100 + 64'(k));
            end
            chk($sformatf("wrap_cnt%0d", k), lq_count_o, (k < 10) ? 1 : 0);
        end
        tick();
        chk("wrap_idle_we", wb_we_o, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
